// File: rtl/ap_txn_pkg.sv
// rtl/ap_txn_pkg.sv - shared types and widths for the ap_ctrl transaction tracker
// Optional feature macro: AP_TXN_STALL_COUNT_EN adds a per-transaction stall field to txn_rec_t.
package ap_txn_pkg;

    localparam int TS_W   = 32;
    localparam int ID_W   = 16;
    localparam int DROP_W = 16;

    typedef logic [TS_W-1:0] ts_t;
    typedef logic [ID_W-1:0] id_t;

    typedef enum logic {
        IN_IDLE   = 1'b0,
        IN_ACTIVE = 1'b1
    } in_state_e;

    // One outstanding start: its timestamp and the gap to the previous accepted start.
    typedef struct packed {
        ts_t start_ts;
        ts_t interval;
    } sq_ent_t;

    typedef struct packed {
        id_t id;
        ts_t start_ts;
        ts_t done_ts;
        ts_t latency;
        ts_t interval;
`ifdef AP_TXN_STALL_COUNT_EN
        ts_t stall;
`endif
    } txn_rec_t;

endpackage

// File: rtl/ap_txn_fifo.sv
// rtl/ap_txn_fifo.sv - parameterised synchronous FIFO for start queue and record queue
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   push_i, data_i  write request and data; accepted when not full or when popping same cycle
//   pop_i           read request; ignored when empty
//   data_o          head entry (registered storage)
//   full_o, empty_o occupancy flags
// DEPTH must be a power of 2 so the pointers wrap naturally.
module ap_txn_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/ap_ctrl_txn_tracker.sv
// rtl/ap_ctrl_txn_tracker.sv - cycle-accurate transaction recorder for one ap_ctrl_hs interface
// Optional feature macro: AP_TXN_STALL_COUNT_EN counts ap_done-without-ap_continue cycles per record.
// Ports:
//   clock, reset                     sole clock, synchronous active-high reset
//   ap_start/ap_ready/ap_done/ap_continue  observed handshake of the monitored block
//   finish                           blocks new starts; outstanding dones still recorded
//   rec_valid/rec_ready/rec_data     record stream to the status monitor
//   drop_cnt                         saturating count of records lost to a full record FIFO
//   err_sq_ovf, err_orphan           sticky error flags
//   idle                             both queues empty and input FSM idle
module ap_ctrl_txn_tracker
    import ap_txn_pkg::*;
#(
    parameter int SQ_DEPTH = 4,
    parameter int RQ_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_continue,
    input  logic              finish,
    output logic              rec_valid,
    input  logic              rec_ready,
    output txn_rec_t          rec_data,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              err_sq_ovf,
    output logic              err_orphan,
    output logic              idle
);

    ts_t               ts_q;
    ts_t               prev_start_q;
    logic              has_prev_q;
    id_t               id_q;
    in_state_e         state_q, state_d;
    logic [DROP_W-1:0] drop_cnt_q;
    logic              err_sq_ovf_q;
    logic              err_orphan_q;

    logic     start_ev, done_ev, bypass;
    logic     sq_push, sq_pop, sq_full, sq_empty, sq_ovf, orphan;
    logic     accepted_start;
    ts_t      start_interval;
    sq_ent_t  sq_in, sq_head;
    logic     rec_push, rec_pop, rec_full, rec_empty, rec_drop;
    txn_rec_t rec_in, rec_head;
    ts_t      rec_start_ts;

`ifdef AP_TXN_STALL_COUNT_EN
    ts_t stall_q;
`endif

    // Event decode. A start only counts on the IN_IDLE side of the handshake so that
    // a held ap_start is not counted again until the block has accepted it.
    assign start_ev = (state_q == IN_IDLE) & ap_start & ~finish;
    assign done_ev  = ap_done & ap_continue;
    // Start and done in the same cycle with nothing outstanding: the done belongs to
    // this very start, so it never touches the start queue.
    assign bypass   = start_ev & done_ev & sq_empty;
    assign sq_pop   = done_ev & ~sq_empty;
    assign sq_push  = start_ev & ~bypass & (~sq_full | sq_pop);
    assign sq_ovf   = start_ev & ~bypass & sq_full & ~sq_pop;
    assign orphan   = done_ev & sq_empty & ~start_ev;

    // Intervals are measured between accepted starts; an overflowed start is lost entirely.
    assign accepted_start = sq_push | bypass;
    assign start_interval = has_prev_q ? (ts_q - prev_start_q) : '0;
    assign sq_in          = '{start_ts: ts_q, interval: start_interval};

    ap_txn_fifo #(
        .WIDTH ($bits(sq_ent_t)),
        .DEPTH (SQ_DEPTH)
    ) u_start_q (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (sq_push),
        .data_i  (sq_in),
        .pop_i   (sq_pop),
        .data_o  (sq_head),
        .full_o  (sq_full),
        .empty_o (sq_empty)
    );

    // Record assembly.
    assign rec_push     = sq_pop | bypass;
    assign rec_start_ts = bypass ? ts_q : sq_head.start_ts;

    always_comb begin
        rec_in          = '0;
        rec_in.id       = id_q;
        rec_in.start_ts = rec_start_ts;
        rec_in.done_ts  = ts_q;
        rec_in.latency  = ts_q - rec_start_ts;
        rec_in.interval = bypass ? start_interval : sq_head.interval;
`ifdef AP_TXN_STALL_COUNT_EN
        rec_in.stall    = stall_q;
`endif
    end

    assign rec_pop  = ~rec_empty & rec_ready;
    assign rec_drop = rec_push & rec_full & ~rec_pop;

    ap_txn_fifo #(
        .WIDTH ($bits(txn_rec_t)),
        .DEPTH (RQ_DEPTH)
    ) u_rec_q (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (rec_push),
        .data_i  (rec_in),
        .pop_i   (rec_pop),
        .data_o  (rec_head),
        .full_o  (rec_full),
        .empty_o (rec_empty)
    );

    assign rec_valid  = ~rec_empty;
    // Storage is not reset, so present zeros while nothing is queued.
    assign rec_data   = rec_empty ? '0 : rec_head;
    assign drop_cnt   = drop_cnt_q;
    assign err_sq_ovf = err_sq_ovf_q;
    assign err_orphan = err_orphan_q;
    assign idle       = sq_empty & rec_empty & (state_q == IN_IDLE);

    // Input FSM: tracks ready even for starts that were blocked by overflow.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IN_IDLE:   if (start_ev && !ap_ready) state_d = IN_ACTIVE;
            IN_ACTIVE: if (ap_ready)              state_d = IN_IDLE;
            default:                              state_d = IN_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_q         <= '0;
            prev_start_q <= '0;
            has_prev_q   <= 1'b0;
            id_q         <= '0;
            state_q      <= IN_IDLE;
            drop_cnt_q   <= '0;
            err_sq_ovf_q <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            ts_q    <= ts_q + 1'b1;
            state_q <= state_d;
            if (accepted_start) begin
                prev_start_q <= ts_q;
                has_prev_q   <= 1'b1;
            end
            // Ids advance per completed transaction, even when its record is dropped.
            if (rec_push) id_q <= id_q + 1'b1;
            if (rec_drop && drop_cnt_q != {DROP_W{1'b1}}) drop_cnt_q <= drop_cnt_q + 1'b1;
            if (sq_ovf) err_sq_ovf_q <= 1'b1;
            if (orphan) err_orphan_q <= 1'b1;
        end
    end

`ifdef AP_TXN_STALL_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset || done_ev) begin
            stall_q <= '0;
        end else if (ap_done && !ap_continue) begin
            stall_q <= stall_q + 1'b1;
        end
    end
`endif

endmodule
